// File: rtl/line_buffer_n.sv
// KSIZE-row vertical line buffer: emits one column of the last KSIZE lines per accepted pixel,
// with per-frame width latch, sof resync, top-border padding and a registered valid/ready output.
module line_buffer_n #(
    parameter int DATA_WIDTH = 8,
    parameter int KSIZE      = 5,
    parameter int MAX_WIDTH  = 1920,
    localparam int W_BITS    = $clog2(MAX_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [W_BITS:0]             cfg_width,
    input  logic                        cfg_pad_mode,
    input  logic                        valid_in,
    input  logic                        sof,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic                        in_ready,
    output logic [KSIZE*DATA_WIDTH-1:0] dout,
    output logic                        dout_valid,
    input  logic                        out_ready,
    output logic [W_BITS-1:0]           dout_col,
    output logic                        dout_eol,
    output logic                        window_full
);

    localparam int RF_BITS = $clog2(KSIZE);
    localparam logic [W_BITS:0]      MAX_W    = (W_BITS+1)'(MAX_WIDTH);
    localparam logic [RF_BITS-1:0]   ROWS_MAX = RF_BITS'(KSIZE-1);

    logic [DATA_WIDTH-1:0] mem [KSIZE-1][MAX_WIDTH];

    logic [W_BITS-1:0]           ptr;
    logic [W_BITS:0]             width_q;
    logic [RF_BITS-1:0]          rows_filled;

    logic                        accept;
    logic [W_BITS:0]             cfg_clamped;
    logic [W_BITS:0]             width_eff;
    logic [W_BITS-1:0]           col;
    logic [W_BITS-1:0]           ptr_next;
    logic                        eol;
    logic [RF_BITS-1:0]          rows_eff;
    logic [RF_BITS-1:0]          oldest;
    logic [RF_BITS-1:0]          rows_next;
    logic [DATA_WIDTH-1:0]       raw [KSIZE];
    logic [DATA_WIDTH-1:0]       fill;
    logic [KSIZE*DATA_WIDTH-1:0] column;

    assign in_ready = out_ready || !dout_valid;
    assign accept   = valid_in && in_ready;

    // An sof beat sees its own width and an empty history, so the frame restarts cleanly.
    always_comb begin
        cfg_clamped = cfg_width;
        if (cfg_width == '0 || cfg_width > MAX_W)
            cfg_clamped = MAX_W;
        width_eff = sof ? cfg_clamped : width_q;
        col       = sof ? '0 : ptr;
        eol       = ({1'b0, col} == width_eff - 1'b1);
        ptr_next  = eol ? '0 : col + 1'b1;
        rows_eff  = sof ? '0 : rows_filled;
        oldest    = ROWS_MAX - rows_eff;
        if (sof)
            rows_next = eol ? RF_BITS'(1) : '0;
        else if (eol && rows_filled != ROWS_MAX)
            rows_next = rows_filled + 1'b1;
        else
            rows_next = rows_filled;
    end

    always_comb begin
        for (int unsigned k = 0; k < KSIZE-1; k++)
            raw[k] = mem[k][col];
        raw[KSIZE-1] = din;

        fill = '0;
        for (int unsigned k = 0; k < KSIZE; k++)
            if (cfg_pad_mode && RF_BITS'(k) == oldest)
                fill = raw[k];

        // Rows above the oldest filled row hold stale or uninitialised memory; mask them.
        column = '0;
        for (int unsigned k = 0; k < KSIZE; k++)
            column[k*DATA_WIDTH +: DATA_WIDTH] = (RF_BITS'(k) >= oldest) ? raw[k] : fill;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned j = 0; j + 2 < KSIZE; j++)
                mem[j][col] <= mem[j+1][col];
            mem[KSIZE-2][col] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            width_q     <= MAX_W;
            rows_filled <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            dout_col    <= '0;
            dout_eol    <= 1'b0;
            window_full <= 1'b0;
        end else if (accept) begin
            ptr         <= ptr_next;
            width_q     <= width_eff;
            rows_filled <= rows_next;
            dout        <= column;
            dout_valid  <= 1'b1;
            dout_col    <= col;
            dout_eol    <= eol;
            window_full <= (rows_eff == ROWS_MAX);
        end else if (out_ready) begin
            dout_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer_n.sv
// Directed self-checking bench for line_buffer_n with KSIZE=5, MAX_WIDTH=8, 8-bit pixels.
module tb_line_buffer_n;

    localparam int DW = 8;
    localparam int KS = 5;
    localparam int MW = 8;
    localparam int WB = 3;

    logic           clk;
    logic           rst_n;
    logic [WB:0]    cfg_width;
    logic           cfg_pad_mode;
    logic           valid_in;
    logic           sof;
    logic [DW-1:0]  din;
    logic           in_ready;
    logic [KS*DW-1:0] dout;
    logic           dout_valid;
    logic           out_ready;
    logic [WB-1:0]  dout_col;
    logic           dout_eol;
    logic           window_full;

    int checks   = 0;
    int failures = 0;
    logic [46:0] got, exp;

    line_buffer_n #(.DATA_WIDTH(DW), .KSIZE(KS), .MAX_WIDTH(MW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_pad_mode(cfg_pad_mode),
        .valid_in(valid_in), .sof(sof), .din(din), .in_ready(in_ready),
        .dout(dout), .dout_valid(dout_valid), .out_ready(out_ready),
        .dout_col(dout_col), .dout_eol(dout_eol), .window_full(window_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arguments are rows k=0 (oldest) .. k=4 (newest).
    function automatic logic [39:0] col5(input logic [7:0] r0, r1, r2, r3, r4);
        return {r4, r3, r2, r1, r0};
    endfunction

    function automatic logic [46:0] mk(input logic [39:0] d, input logic [2:0] c,
                                       input logic e, input logic w);
        return {1'b1, d, c, e, w};
    endfunction

    function automatic logic [46:0] obs();
        return {dout_valid, dout, dout_col, dout_eol, window_full};
    endfunction

    task automatic send(input logic [7:0] d, input logic s);
        int n;
        n = 0;
        valid_in = 1'b1;
        din      = d;
        sof      = s;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_ready_timeout got in_ready=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        got = obs(); checks++;
        if (got !== 47'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", got, 47'd0);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_pad();
        cfg_width = 4'd4; cfg_pad_mode = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            send(8'(i), i == 1);
            checks++;
            if (dout_col !== 3'((i-1) % 4)) begin
                failures++; $display("FAIL zp_col beat=%0d got=%0d exp=%0d", i, dout_col, (i-1) % 4);
            end
            exp = '0;
            if (i == 1)  exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd0, 8'd1), 3'd0, 1'b0, 1'b0);
            if (i == 4)  exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd0, 8'd4), 3'd3, 1'b1, 1'b0);
            if (i == 5)  exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd1, 8'd5), 3'd0, 1'b0, 1'b0);
            if (i == 17) exp = mk(col5(8'd1, 8'd5, 8'd9, 8'd13, 8'd17), 3'd0, 1'b0, 1'b1);
            if (i == 20) exp = mk(col5(8'd4, 8'd8, 8'd12, 8'd16, 8'd20), 3'd3, 1'b1, 1'b1);
            if (exp != '0) begin
                got = obs(); checks++;
                if (got !== exp) begin
                    failures++; $display("FAIL zp_beat%0d got=%h exp=%h", i, got, exp);
                end
            end
        end
    endtask

    task automatic test_replicate();
        cfg_width = 4'd4; cfg_pad_mode = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            send(8'(i), i == 1);
            exp = '0;
            if (i == 1) exp = mk(col5(8'd1, 8'd1, 8'd1, 8'd1, 8'd1), 3'd0, 1'b0, 1'b0);
            if (i == 6) exp = mk(col5(8'd2, 8'd2, 8'd2, 8'd2, 8'd6), 3'd1, 1'b0, 1'b0);
            if (i == 9) exp = mk(col5(8'd1, 8'd1, 8'd1, 8'd5, 8'd9), 3'd0, 1'b0, 1'b0);
            if (exp != '0) begin
                got = obs(); checks++;
                if (got !== exp) begin
                    failures++; $display("FAIL rep_beat%0d got=%h exp=%h", i, got, exp);
                end
            end
        end
        cfg_pad_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        cfg_width = 4'd4;
        send(8'd101, 1'b1);
        send(8'd102, 1'b0);
        out_ready = 1'b0;
        valid_in  = 1'b1; din = 8'd103;
        exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd0, 8'd102), 3'd1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready);
            end
            got = obs(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        got = obs(); exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd0, 8'd103), 3'd2, 1'b0, 1'b0);
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL bp_after_release got=%h exp=%h", got, exp);
        end
        send(8'd104, 1'b0);
        got = obs(); exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd0, 8'd104), 3'd3, 1'b1, 1'b0);
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL bp_eol got=%h exp=%h", got, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            failures++; $display("FAIL bp_idle_valid got=%b exp=0", dout_valid);
        end
    endtask

    task automatic test_width_change();
        logic [WB:0] cfgs [3];
        int          expw [3];
        cfgs[0] = 4'd6; cfgs[1] = 4'd0; cfgs[2] = 4'd9;
        expw[0] = 6;    expw[1] = 8;    expw[2] = 8;
        for (int f = 0; f < 3; f++) begin
            cfg_width = cfgs[f];
            for (int i = 0; i < expw[f]; i++) begin
                send(8'(50 + i), i == 0);
                // A width change without sof must not affect the current frame.
                if (i == 0) cfg_width = 4'd3;
                checks++;
                if (dout_col !== 3'(i) || dout_eol !== (i == expw[f] - 1)) begin
                    failures++;
                    $display("FAIL wc_frame%0d beat=%0d got col=%0d eol=%b exp col=%0d eol=%b",
                             f, i, dout_col, dout_eol, i, (i == expw[f] - 1));
                end
            end
        end
    endtask

    task automatic test_midline_sof();
        cfg_width = 4'd4; cfg_pad_mode = 1'b0;
        for (int i = 0; i < 10; i++)
            send(8'(10 * (i / 4 + 1) + (i % 4) + 1), i == 0);
        send(8'd41, 1'b1);
        got = obs(); exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd0, 8'd41), 3'd0, 1'b0, 1'b0);
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL ms_sof_beat got=%h exp=%h", got, exp);
        end
        send(8'd42, 1'b0);
        got = obs(); exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd0, 8'd42), 3'd1, 1'b0, 1'b0);
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL ms_stale_masked got=%h exp=%h", got, exp);
        end
        send(8'd43, 1'b0);
        send(8'd44, 1'b0);
        got = obs(); exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd0, 8'd44), 3'd3, 1'b1, 1'b0);
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL ms_eol got=%h exp=%h", got, exp);
        end
        send(8'd51, 1'b0);
        got = obs(); exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd41, 8'd51), 3'd0, 1'b0, 1'b0);
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL ms_next_line got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_reset_midframe();
        cfg_width = 4'd4; cfg_pad_mode = 1'b0;
        for (int i = 1; i <= 17; i++)
            send(8'(i), i == 1);
        got = obs(); exp = mk(col5(8'd1, 8'd5, 8'd9, 8'd13, 8'd17), 3'd0, 1'b0, 1'b1);
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL rm_prefill got=%h exp=%h", got, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        got = obs(); checks++;
        if (got !== 47'd0) begin
            failures++; $display("FAIL rm_async_drop got=%h exp=%h", got, 47'd0);
        end
        rst_n = 1'b1;
        send(8'd77, 1'b0);
        got = obs(); exp = mk(col5(8'd0, 8'd0, 8'd0, 8'd0, 8'd77), 3'd0, 1'b0, 1'b0);
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL rm_first_beat got=%h exp=%h", got, exp);
        end
        for (int i = 1; i < 8; i++) begin
            send(8'(77 + i), 1'b0);
            checks++;
            if (dout_col !== 3'(i) || dout_eol !== (i == 7)) begin
                failures++;
                $display("FAIL rm_default_width beat=%0d got col=%0d eol=%b exp col=%0d eol=%b",
                         i, dout_col, dout_eol, i, (i == 7));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_width = '0; cfg_pad_mode = 1'b0;
        valid_in = 1'b0; sof = 1'b0; din = '0; out_ready = 1'b1;
        test_reset();
        test_zero_pad();
        test_replicate();
        test_backpressure();
        test_width_change();
        test_midline_sof();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
